// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the CY7C1399B SRAM interface.
// Issues one single-cycle read/write strobe at a time and owns the interface enable line.
module sram_arbiter #(
  parameter int NUM_ADDRESS_LINES = 10,
  parameter int DATA_WIDTH        = 8,
  parameter int READ_LAT          = 3,
  parameter int WRITE_LAT         = 3,
  parameter int WAKE_CYCLES       = 3
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         a_req,
  input  logic                         a_we,
  input  logic [NUM_ADDRESS_LINES-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]        a_wdata,
  output logic                         a_ack,
  output logic                         a_rvalid,
  output logic [DATA_WIDTH-1:0]        a_rdata,
  input  logic                         b_req,
  input  logic                         b_we,
  input  logic [NUM_ADDRESS_LINES-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]        b_wdata,
  output logic                         b_ack,
  output logic                         b_rvalid,
  output logic [DATA_WIDTH-1:0]        b_rdata,
  input  logic                         sleep,
  output logic                         sram_enable,
  output logic                         read_from_sram,
  output logic                         write_to_sram,
  output logic [NUM_ADDRESS_LINES-1:0] w_addr,
  output logic [NUM_ADDRESS_LINES-1:0] r_addr,
  output logic [DATA_WIDTH-1:0]        d_in,
  input  logic [DATA_WIDTH-1:0]        d_out,
  input  logic                         data_valid,
  output logic                         busy,
  output logic                         err
);

  localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_MAX = (LAT_MAX > WAKE_CYCLES) ? LAT_MAX : WAKE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SLEEP, WAKE} state_t;

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic                           last_grant_b;
  logic                           grant_b;
  logic                           lat_we;
  logic [NUM_ADDRESS_LINES-1:0]   lat_addr;
  logic                           pick_b;
  logic                           sel_we;

  // B wins when it is alone, or on a tie when A was served last.
  always_comb begin
    pick_b = b_req && (!a_req || !last_grant_b);
    sel_we = pick_b ? b_we : a_we;
  end

  assign w_addr = lat_addr;
  assign r_addr = lat_addr;
  assign busy   = (state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state          <= WAKE;
      cnt            <= CW'(WAKE_CYCLES);
      last_grant_b   <= 1'b1;
      grant_b        <= 1'b0;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      d_in           <= '0;
      sram_enable    <= 1'b1;
      read_from_sram <= 1'b0;
      write_to_sram  <= 1'b0;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      a_rdata        <= '0;
      b_rdata        <= '0;
      err            <= 1'b0;
    end else begin
      read_from_sram <= 1'b0;
      write_to_sram  <= 1'b0;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      case (state)
        IDLE: begin
          if (sleep) begin
            sram_enable <= 1'b0;
            state       <= SLEEP;
          end else if (a_req || b_req) begin
            grant_b        <= pick_b;
            last_grant_b   <= pick_b;
            lat_we         <= sel_we;
            lat_addr       <= pick_b ? b_addr : a_addr;
            d_in           <= pick_b ? b_wdata : a_wdata;
            // Strobe is registered here so it is high during the ISSUE cycle.
            read_from_sram <= !sel_we;
            write_to_sram  <= sel_we;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= lat_we ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) begin
            if (!lat_we) begin
              if (grant_b) b_rdata <= d_out;
              else         a_rdata <= d_out;
              if (!data_valid) err <= 1'b1;
              a_rvalid <= !grant_b;
              b_rvalid <= grant_b;
            end
            a_ack <= !grant_b;
            b_ack <= grant_b;
            state <= IDLE;
          end
        end
        SLEEP: begin
          if (!sleep) begin
            sram_enable <= 1'b1;
            cnt         <= CW'(WAKE_CYCLES);
            state       <= WAKE;
          end
        end
        WAKE: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter: writes, reads, round-robin ties,
// sleep/wake guard, mid-command reset and sticky read error.
module tb_sram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_ack, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ack, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          sleep = 1'b0;
  logic          sram_enable, read_from_sram, write_to_sram;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out = '0;
  logic          data_valid = 1'b1;
  logic          busy, err;

  int n_checks = 0;
  int n_fail = 0;
  int both_cnt = 0;
  int a_ack_cnt = 0;
  int b_ack_cnt = 0;

  sram_arbiter #(
    .NUM_ADDRESS_LINES(AW),
    .DATA_WIDTH(DW),
    .READ_LAT(3),
    .WRITE_LAT(3),
    .WAKE_CYCLES(3)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sleep(sleep), .sram_enable(sram_enable),
    .read_from_sram(read_from_sram), .write_to_sram(write_to_sram),
    .w_addr(w_addr), .r_addr(r_addr), .d_in(d_in),
    .d_out(d_out), .data_valid(data_valid),
    .busy(busy), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (read_from_sram && write_to_sram) both_cnt++;
    if (a_ack) a_ack_cnt++;
    if (b_ack) b_ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Returns the number of cycles until a strobe is seen, or -1 after 30 cycles.
  task automatic wait_strobe(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (read_from_sram || write_to_sram) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int ack_before;
    logic stb;

    tick();
    tick();
    check("rst_enable", 32'(sram_enable), 1);
    check("rst_strobes", 32'({read_from_sram, write_to_sram}), 0);
    check("rst_acks", 32'({a_ack, b_ack, a_rvalid, b_rvalid}), 0);
    check("rst_err", 32'(err), 0);
    check("rst_addr", 32'(w_addr), 0);
    check("rst_din", 32'(d_in), 0);
    check("rst_busy", 32'(busy), 1);

    // A write 0x012 <- 0x5A
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h012; a_wdata = 8'h5A;
    rst = 1'b0;
    wait_strobe(n);
    check("t1_latency", n, 4);
    check("t1_wstb", 32'(write_to_sram), 1);
    check("t1_rstb", 32'(read_from_sram), 0);
    check("t1_waddr", 32'(w_addr), 'h012);
    check("t1_din", 32'(d_in), 'h5A);
    tick();
    check("t1_wstb_off", 32'(write_to_sram), 0);
    check("t1_ack_early1", 32'(a_ack), 0);
    tick();
    check("t1_ack_early2", 32'(a_ack), 0);
    tick();
    check("t1_ack", 32'(a_ack), 1);
    check("t1_rvalid", 32'(a_rvalid), 0);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_waddr_hold", 32'(w_addr), 'h012);
    check("t1_no_back", b_ack_cnt, 0);
    a_req = 1'b0;

    // B read 0x012, model returns 0xA5
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h012; d_out = 8'hA5; data_valid = 1'b1;
    wait_strobe(n);
    check("t2_latency", n, 1);
    check("t2_rstb", 32'(read_from_sram), 1);
    check("t2_raddr", 32'(r_addr), 'h012);
    tick();
    check("t2_rstb_off", 32'(read_from_sram), 0);
    tick();
    tick();
    check("t2_back", 32'(b_ack), 1);
    check("t2_brvalid", 32'(b_rvalid), 1);
    check("t2_brdata", 32'(b_rdata), 'hA5);
    check("t2_err", 32'(err), 0);
    check("t2_no_aack", 32'(a_ack), 0);
    b_req = 1'b0;

    // Continuous tie from reset: A, B, A, B, strobes 4 cycles apart
    rst = 1'b1;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    a_addr = 10'h100; b_addr = 10'h200; d_out = 8'h77;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(n);
      check((k == 0) ? "t3_first" : "t3_gap", n, 4);
      check("t3_order", 32'(r_addr), (k % 2 == 0) ? 'h100 : 'h200);
      if (k == 3) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    tick();
    tick();
    tick();
    check("t3_last_back", 32'(b_ack), 1);
    check("t3_brdata", 32'(b_rdata), 'h77);
    check("t3_ardata", 32'(a_rdata), 'h77);
    check("t3_no_both", both_cnt, 0);

    // Sleep with A pending, then guarded wake-up
    sleep = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h055; a_wdata = 8'h33;
    tick();
    check("t4_en_low", 32'(sram_enable), 0);
    check("t4_busy", 32'(busy), 1);
    stb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (read_from_sram || write_to_sram) stb = 1'b1;
    end
    check("t4_no_strobe", 32'(stb), 0);
    sleep = 1'b0;
    tick();
    check("t4_en_high", 32'(sram_enable), 1);
    wait_strobe(n);
    check("t4_guard", n, 4);
    check("t4_wstb", 32'(write_to_sram), 1);
    check("t4_waddr", 32'(w_addr), 'h055);
    tick();
    tick();
    tick();
    check("t4_ack", 32'(a_ack), 1);
    a_req = 1'b0;

    // Reset one cycle after a write strobe
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h0AA; a_wdata = 8'hC3;
    wait_strobe(n);
    check("t5_latency", n, 1);
    ack_before = a_ack_cnt;
    tick();
    rst = 1'b1;
    tick();
    check("t5_strobes", 32'({read_from_sram, write_to_sram}), 0);
    check("t5_ack", 32'(a_ack), 0);
    check("t5_enable", 32'(sram_enable), 1);
    check("t5_waddr", 32'(w_addr), 0);
    check("t5_din", 32'(d_in), 0);
    rst = 1'b0;
    wait_strobe(n);
    check("t5_guard", 32'(n >= 4), 1);
    check("t5_no_ack", a_ack_cnt, ack_before);
    tick();
    tick();
    tick();
    check("t5_reissue_ack", 32'(a_ack), 1);
    a_req = 1'b0;

    // Read with data_valid low sets sticky err
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h001; d_out = 8'h99; data_valid = 1'b0;
    wait_strobe(n);
    check("t6_latency", n, 1);
    tick();
    tick();
    tick();
    check("t6_arvalid", 32'(a_rvalid), 1);
    check("t6_ardata", 32'(a_rdata), 'h99);
    check("t6_err", 32'(err), 1);
    a_req = 1'b0;
    data_valid = 1'b1; d_out = 8'h11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h003;
    wait_strobe(n);
    tick();
    tick();
    tick();
    check("t6_brvalid", 32'(b_rvalid), 1);
    check("t6_brdata", 32'(b_rdata), 'h11);
    check("t6_ardata_hold", 32'(a_rdata), 'h99);
    check("t6_err_sticky", 32'(err), 1);
    b_req = 1'b0;
    rst = 1'b1;
    tick();
    check("t6_err_cleared", 32'(err), 0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
